snn_timestep_scheduler: RTL
===========================

Name: snn_timestep_scheduler

Overview:
Sequences one leaky-integrate-and-fire timestep across NUM_NEURONS neurons that share a single accumulate/leak/threshold datapath. It walks every (neuron, input) pair, fetches the weight from the user-area weight memory with a 1-cycle read latency, integrates the weights of active input spikes, then applies leak, saturation, threshold and reset. It sits in the user project between the LA/Wishbone control registers (start, threshold, leak, input spikes) and the weight SRAM. Output spikes and membrane potentials are exposed for firmware readback.

Parameters:
NUM_INPUTS, 16, input spike lines per timestep (power of 2)
NUM_NEURONS, 8, neurons time-multiplexed on the datapath (power of 2)
WEIGHT_W, 8, signed weight width
POT_W, 16, signed membrane potential width

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
start_i  in  1  begin one timestep; sampled only in IDLE
clear_i  in  1  zero all potentials and the timestep counter; acted on only in IDLE
spikes_in_i  in  NUM_INPUTS  input spike vector; latched on start acceptance
threshold_i  in  POT_W  signed firing threshold
leak_shift_i  in  4  leak = V>>>leak_shift; 0 means no leak
weight_re_o  out  1  weight read strobe
weight_addr_o  out  log2(NUM_NEURONS)+log2(NUM_INPUTS)  n*NUM_INPUTS+i
weight_data_i  in  WEIGHT_W  signed weight, valid the cycle after weight_re_o
busy_o  out  1  high whenever state is not IDLE
done_o  out  1  one-cycle pulse at timestep completion
spikes_out_o  out  NUM_NEURONS  spike vector of the last completed timestep
timestep_cnt_o  out  16  completed timesteps; wraps 0xFFFF->0
pot_sel_i  in  log2(NUM_NEURONS)  potential readback select
pot_o  out  POT_W  potential of neuron pot_sel_i (combinational read)

Behaviour:
- Reset: state IDLE; all outputs 0; all potentials 0; accumulator 0; latched spikes 0.
- States: IDLE, ACCUM, UPDATE, DONE.
- IDLE: clear_i=1 zeroes potentials and timestep_cnt_o, and start_i is ignored that cycle (clear wins). Otherwise start_i=1 latches spikes_in_i, sets n=0, i=0, acc=0, goes to ACCUM.
- ACCUM: runs NUM_INPUTS+1 cycles per neuron.
  - Cycles 0..NUM_INPUTS-1: weight_re_o=1 with addr n*NUM_INPUTS+i.
  - Each cycle after a read: acc += sign-extended weight_data_i if latched spike[i-1]=1.
  - Last cycle is the drain (weight_re_o=0); then go to UPDATE.
  - acc is signed, POT_W+log2(NUM_INPUTS) bits wide; it never overflows.
- UPDATE (1 cycle):
  - V' = V - (leak_shift_i==0 ? 0 : V>>>leak_shift_i) + acc, computed at full width, then saturated to [-2^(POT_W-1), 2^(POT_W-1)-1].
  - If V' >= threshold_i (signed compare): spike bit n=1 and V=0. Else store V'.
  - acc cleared. If n==NUM_NEURONS-1 go to DONE; else n++, i=0, go to ACCUM.
- DONE (1 cycle): done_o=1; spikes_out_o updated from the working spike vector; timestep_cnt_o++; next state IDLE.
- Latency: start sampled at edge 0 gives done_o high in cycle 1+NUM_NEURONS*(NUM_INPUTS+2). Defaults: cycle 145.
- busy_o=1 from cycle 1 through the DONE cycle inclusive.
- start_i and clear_i while busy are ignored (not queued).
- spikes_in_i and threshold_i/leak_shift_i changes mid-timestep: spikes use the latched value; threshold/leak are sampled live in UPDATE, and firmware holds them stable.
- wb_rst_i mid-operation: at the next edge everything returns to reset values, weight_re_o=0, no done_o.

Decomposition:
- Package snn_pkg: state enum, saturation limits POT_MAX/POT_MIN, address-width function, ACC_W constant.
- Sub-module snn_lif_update: combinational leak/add/saturate/threshold returning V_next and spike. It is reused by future multi-lane datapaths.

Test Plan:
1. Assert wb_rst_i 3 cycles -> all outputs 0, busy_o=0, pot_o=0 for every pot_sel_i.
2. Weights all 10, spikes_in_i=16'h000F, threshold=100, leak 0, three timesteps:
   - Potentials go 40 then 80, spikes_out 8'h00.
   - Third timestep gives spikes_out_o=8'hFF and potentials 0.
   - done_o in cycle 145 after each start; weight_addr_o sequence 0..127 once per timestep.
3. Leak: leak_shift=1, neuron-0 weights 4, spikes_in=16'hFFFF (acc=64), threshold=1000 -> potential 64, then 96, then 112.
4. Saturation: weights 127, all spikes, threshold 16'h7FFF -> after 16 timesteps V=32512, no spike. Timestep 17 saturates to 32767 and spikes.
   Negative case: weights -128 -> V clamps at -32768 and stays there.
5. start_i pulsed at cycles 10 and 144 during a timestep -> ignored, one done_o only. clear_i+start_i together in IDLE -> potentials 0, busy_o stays 0.
6. wb_rst_i at cycle 50 of a timestep -> busy_o=0, weight_re_o=0 next cycle, no done_o, potentials 0, timestep_cnt_o=0.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared constants and helpers for the SNN timestep scheduler.
// State encodings, default saturation limits and width helpers.
package snn_pkg;

  // Scheduler FSM state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Saturation limits for the default 16-bit membrane potential
  localparam int               DEF_POT_W = 16;
  localparam logic signed [15:0] POT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] POT_MIN = 16'sh8000;

  // Weight address width: neuron index concatenated with input index
  function automatic int addr_width(input int num_neurons, input int num_inputs);
    return $clog2(num_neurons) + $clog2(num_inputs);
  endfunction

  // Accumulator width: wide enough that NUM_INPUTS weights can never overflow it
  function automatic int acc_width(input int pot_w, input int num_inputs);
    return pot_w + $clog2(num_inputs);
  endfunction

endpackage

// File: rtl/snn_lif_update.sv
// Combinational leaky-integrate-and-fire update for one neuron:
// leak, add accumulated input, saturate to the potential range, threshold.
module snn_lif_update #(
  parameter int POT_W = 16,
  parameter int ACC_W = 20
) (
  input  logic signed [POT_W-1:0] v,
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [POT_W-1:0] threshold,
  input  logic [3:0]              leak_shift,
  output logic signed [POT_W-1:0] v_next,
  output logic                    spike
);

  // Two guard bits above the accumulator width so V - leak + acc is exact
  localparam int EXT_W = ACC_W + 2;
  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-POT_W+1){1'b0}}, {(POT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-POT_W+1){1'b1}}, {(POT_W-1){1'b0}}};

  logic signed [POT_W-1:0] leak;
  logic signed [EXT_W-1:0] v_ext;
  logic signed [EXT_W-1:0] leak_ext;
  logic signed [EXT_W-1:0] acc_ext;
  logic signed [EXT_W-1:0] sum;

  // Leak, integrate, saturate and compare against the firing threshold
  always_comb begin
    if (leak_shift == 4'd0) begin
      leak = '0;
    end else begin
      leak = v >>> leak_shift;
    end
    v_ext    = {{(EXT_W-POT_W){v[POT_W-1]}}, v};
    leak_ext = {{(EXT_W-POT_W){leak[POT_W-1]}}, leak};
    acc_ext  = {{(EXT_W-ACC_W){acc[ACC_W-1]}}, acc};
    sum      = v_ext - leak_ext + acc_ext;
    if (sum > SAT_MAX) begin
      v_next = SAT_MAX[POT_W-1:0];
    end else if (sum < SAT_MIN) begin
      v_next = SAT_MIN[POT_W-1:0];
    end else begin
      v_next = sum[POT_W-1:0];
    end
    spike = (v_next >= threshold);
  end

endmodule

// File: rtl/snn_timestep_scheduler.sv
// Timestep scheduler: walks every (neuron, input) pair over a shared
// LIF datapath, fetching weights from a 1-cycle-latency weight memory.
module snn_timestep_scheduler
  import snn_pkg::*;
#(
  parameter int NUM_INPUTS  = 16,
  parameter int NUM_NEURONS = 8,
  parameter int WEIGHT_W    = 8,
  parameter int POT_W       = 16,
  localparam int IDX_W  = $clog2(NUM_INPUTS),
  localparam int NRN_W  = $clog2(NUM_NEURONS),
  localparam int ADDR_W = addr_width(NUM_NEURONS, NUM_INPUTS),
  localparam int ACC_W  = acc_width(POT_W, NUM_INPUTS)
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   start_i,
  input  logic                   clear_i,
  input  logic [NUM_INPUTS-1:0]  spikes_in_i,
  input  logic [POT_W-1:0]       threshold_i,
  input  logic [3:0]             leak_shift_i,
  output logic                   weight_re_o,
  output logic [ADDR_W-1:0]      weight_addr_o,
  input  logic [WEIGHT_W-1:0]    weight_data_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [NUM_NEURONS-1:0] spikes_out_o,
  output logic [15:0]            timestep_cnt_o,
  input  logic [NRN_W-1:0]       pot_sel_i,
  output logic [POT_W-1:0]       pot_o
);

  // Input counter has one extra bit to reach the drain cycle (idx == NUM_INPUTS)
  localparam int IC_W = IDX_W + 1;
  localparam logic [IC_W-1:0]  IDX_LAST_RD = IC_W'(NUM_INPUTS - 1);
  localparam logic [IC_W-1:0]  IDX_DRAIN   = IC_W'(NUM_INPUTS);
  localparam logic [NRN_W-1:0] NRN_LAST    = NRN_W'(NUM_NEURONS - 1);

  logic [1:0]              state;
  logic [IC_W-1:0]         idx;
  logic [IC_W-1:0]         idx_p1;
  logic [IDX_W-1:0]        prev_idx;
  logic [NRN_W-1:0]        nrn;
  logic [NRN_W-1:0]        nrn_p1;
  logic [NUM_INPUTS-1:0]   spk_lat;
  logic [NUM_NEURONS-1:0]  spk_work;
  logic [NUM_NEURONS-1:0]  spk_work_nx;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] wdata_ext;
  logic signed [POT_W-1:0] pot [NUM_NEURONS];
  logic signed [POT_W-1:0] lif_v_next;
  logic                    lif_spike;

  snn_lif_update #(
    .POT_W (POT_W),
    .ACC_W (ACC_W)
  ) u_lif (
    .v          (pot[nrn]),
    .acc        (acc),
    .threshold  (threshold_i),
    .leak_shift (leak_shift_i),
    .v_next     (lif_v_next),
    .spike      (lif_spike)
  );

  // Counter increments, sign-extended weight and the working spike vector with this neuron's result
  always_comb begin
    idx_p1      = idx + IC_W'(1);
    prev_idx    = idx[IDX_W-1:0] - IDX_W'(1);
    nrn_p1      = nrn + NRN_W'(1);
    wdata_ext   = {{(ACC_W-WEIGHT_W){weight_data_i[WEIGHT_W-1]}}, weight_data_i};
    spk_work_nx = spk_work;
    if (lif_spike) begin
      spk_work_nx[nrn] = 1'b1;
    end else begin
      spk_work_nx[nrn] = spk_work[nrn];
    end
  end

  // Sequencer: FSM, counters, accumulator and registered outputs
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state          <= ST_IDLE;
      idx            <= '0;
      nrn            <= '0;
      acc            <= '0;
      spk_lat        <= '0;
      spk_work       <= '0;
      weight_re_o    <= 1'b0;
      weight_addr_o  <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      spikes_out_o   <= '0;
      timestep_cnt_o <= 16'd0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clear_i) begin
            timestep_cnt_o <= 16'd0;
          end else if (start_i) begin
            spk_lat       <= spikes_in_i;
            spk_work      <= '0;
            nrn           <= '0;
            idx           <= '0;
            acc           <= '0;
            weight_re_o   <= 1'b1;
            weight_addr_o <= '0;
            busy_o        <= 1'b1;
            state         <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          // Data returned for the read issued last cycle belongs to input idx-1
          if ((idx != IC_W'(0)) && spk_lat[prev_idx]) begin
            acc <= acc + wdata_ext;
          end
          if (idx == IDX_DRAIN) begin
            state <= ST_UPDATE;
          end else begin
            idx <= idx_p1;
          end
          weight_re_o   <= (idx < IDX_LAST_RD);
          weight_addr_o <= {nrn, idx_p1[IDX_W-1:0]};
        end
        ST_UPDATE: begin
          acc      <= '0;
          spk_work <= spk_work_nx;
          if (nrn == NRN_LAST) begin
            // Publish results so they are visible during the done pulse
            done_o         <= 1'b1;
            spikes_out_o   <= spk_work_nx;
            timestep_cnt_o <= timestep_cnt_o + 16'd1;
            state          <= ST_DONE;
          end else begin
            nrn           <= nrn_p1;
            idx           <= '0;
            weight_re_o   <= 1'b1;
            weight_addr_o <= {nrn_p1, {IDX_W{1'b0}}};
            state         <= ST_ACCUM;
          end
        end
        ST_DONE: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          busy_o      <= 1'b0;
          weight_re_o <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  // Membrane potential storage: cleared in IDLE, written back once per neuron in UPDATE
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        pot[k] <= '0;
      end
    end else if ((state == ST_IDLE) && clear_i) begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        pot[k] <= '0;
      end
    end else if (state == ST_UPDATE) begin
      pot[nrn] <= lif_spike ? '0 : lif_v_next;
    end
  end

  assign pot_o = pot[pot_sel_i];

endmodule
